// File: rtl/tone_sequencer.sv
// tone_sequencer: FIFO-fed square-wave note player. Notes are {freq, dur}
// pairs; each note plays as a phase-accumulator square wave for dur ms,
// optionally followed by a silent gap of gap_ms ms.
module tone_sequencer #(
  parameter int FREQ_W = 10,
  parameter int DUR_W  = 10,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                ticks_per_milli,
  input  logic                       note_valid,
  output logic                       note_ready,
  input  logic [FREQ_W-1:0]          note_freq,
  input  logic [DUR_W-1:0]           note_dur,
  input  logic [7:0]                 gap_ms,
  input  logic                       flush,
  input  logic                       pause,
  output logic                       sound,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [FREQ_W-1:0]          cur_freq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int LEN_W = (DUR_W > 8) ? DUR_W : 8;
  localparam int ENT_W = FREQ_W + DUR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;

  // Playback state and timing
  state_t            state_r;
  state_t            state_next;
  logic [15:0]       tick_r;
  logic [LEN_W-1:0]  ms_cnt_r;
  logic [LEN_W-1:0]  len_r;
  logic [31:0]       acc_r;
  logic [FREQ_W-1:0] freq_r;
  logic              tone_r;

  // Combinational helpers
  logic              push_s;
  logic              pop_s;
  logic              take_s;
  logic              start_tone_s;
  logic              start_gap_s;
  logic              have_note_s;
  logic [15:0]       tpm_eff_s;
  logic [31:0]       half_s;
  logic              ms_tick_s;
  logic              last_ms_s;
  logic [ENT_W-1:0]  head_s;
  logic [FREQ_W-1:0] head_freq_s;
  logic [DUR_W-1:0]  head_dur_s;
  logic [31:0]       freq_ext_s;

  // Timing helpers: effective tick rate, half period, ms tick and FIFO head
  always_comb begin
    tpm_eff_s   = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    // (tpm*1000)>>1 is exactly tpm*500 because tpm*1000 is always even;
    // 16 bits * 500 fits well inside 32 bits, so nothing truncates.
    half_s      = {16'd0, tpm_eff_s} * 32'd500;
    ms_tick_s   = (tick_r == (tpm_eff_s - 16'd1));
    last_ms_s   = ms_tick_s && (ms_cnt_r == (len_r - LEN_W'(1'b1)));
    have_note_s = (level_r != {LVL_W{1'b0}});
    head_s      = mem_r[rd_ptr_r];
    head_dur_s  = head_s[DUR_W-1:0];
    head_freq_s = head_s[ENT_W-1:DUR_W];
    freq_ext_s  = {{(32-FREQ_W){1'b0}}, freq_r};
    push_s      = note_valid && note_ready;
  end

  // FIFO write port (payload only, no reset needed on storage)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {note_freq, note_dur};
    end
  end

  // FIFO pointers and occupancy; reset and flush empty the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic: note end, gap end and popping the next note
  always_comb begin
    state_next   = state_r;
    take_s       = 1'b0;
    pop_s        = 1'b0;
    start_tone_s = 1'b0;
    start_gap_s  = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else if (pause) begin
      state_next = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (have_note_s) begin
            take_s = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        TONE: begin
          if (last_ms_s) begin
            if (gap_ms != 8'd0) begin
              state_next  = GAP;
              start_gap_s = 1'b1;
            end else if (have_note_s) begin
              take_s = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next = TONE;
          end
        end
        GAP: begin
          if (last_ms_s) begin
            if (have_note_s) begin
              take_s = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next = GAP;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
      // A popped zero-length note never plays; it behaves like a note that
      // just ended (gap if requested, otherwise IDLE picks up the next one).
      if (take_s) begin
        pop_s = 1'b1;
        if (head_dur_s != {DUR_W{1'b0}}) begin
          state_next   = TONE;
          start_tone_s = 1'b1;
        end else if (gap_ms != 8'd0) begin
          state_next  = GAP;
          start_gap_s = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end else begin
        pop_s = 1'b0;
      end
    end
  end

  // Timing counters, phase accumulator, current note and square-wave level
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tick_r   <= 16'd0;
      ms_cnt_r <= {LEN_W{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      acc_r    <= 32'd0;
      freq_r   <= {FREQ_W{1'b0}};
      tone_r   <= 1'b0;
    end else if (pause) begin
      tick_r   <= tick_r;
      ms_cnt_r <= ms_cnt_r;
      acc_r    <= acc_r;
      tone_r   <= tone_r;
    end else if (start_tone_s) begin
      tick_r   <= 16'd0;
      ms_cnt_r <= {LEN_W{1'b0}};
      len_r    <= LEN_W'(head_dur_s);
      acc_r    <= 32'd0;
      freq_r   <= head_freq_s;
      tone_r   <= 1'b0;
    end else if (start_gap_s) begin
      tick_r   <= 16'd0;
      ms_cnt_r <= {LEN_W{1'b0}};
      len_r    <= LEN_W'(gap_ms);
      acc_r    <= 32'd0;
      freq_r   <= {FREQ_W{1'b0}};
      tone_r   <= 1'b0;
    end else if (state_next == IDLE) begin
      tick_r   <= 16'd0;
      ms_cnt_r <= {LEN_W{1'b0}};
      acc_r    <= 32'd0;
      freq_r   <= {FREQ_W{1'b0}};
      tone_r   <= 1'b0;
    end else begin
      if (ms_tick_s) begin
        tick_r   <= 16'd0;
        ms_cnt_r <= ms_cnt_r + LEN_W'(1'b1);
      end else begin
        tick_r   <= tick_r + 16'd1;
      end
      // Compare the pre-add accumulator against the half period
      if ((state_r == TONE) && (freq_r != {FREQ_W{1'b0}})) begin
        if (acc_r >= half_s) begin
          acc_r  <= acc_r + freq_ext_s - half_s;
          tone_r <= ~tone_r;
        end else begin
          acc_r  <= acc_r + freq_ext_s;
        end
      end
    end
  end

  // Output decode; pause silences the wave immediately while state is held
  always_comb begin
    note_ready = (level_r != LVL_W'(DEPTH)) && !flush && !rst;
    busy       = (state_r != IDLE) || (level_r != {LVL_W{1'b0}});
    sound      = tone_r && !pause;
    level      = level_r;
    cur_freq   = freq_r;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter FREQ_W, default 10, meaning note frequency width in Hz.
REQ-002 SHALL have parameter DUR_W, default 10, meaning note duration width in ms.
REQ-003 SHALL have parameter DEPTH, default 8, meaning note FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port ticks_per_milli  in  16  meaning clk cycles per ms (0 treated as 1).
REQ-007 SHALL have port note_valid  in  1  meaning a note is offered for push.
REQ-008 SHALL have port note_ready  out  1  meaning the FIFO accepts a push this cycle.
REQ-009 SHALL have port note_freq  in  FREQ_W  meaning tone in Hz; 0 = rest (silent note).
REQ-010 SHALL have port note_dur  in  DUR_W  meaning note length in ms.
REQ-011 SHALL have port gap_ms  in  8  meaning silence inserted after each note, sampled at note end.
REQ-012 SHALL have port flush  in  1  meaning abort the current note and empty the FIFO.
REQ-013 SHALL have port pause  in  1  meaning freeze playback timing.
REQ-014 SHALL have port sound  out  1  meaning square-wave audio output.
REQ-015 SHALL have port busy  out  1  meaning a note is playing, gapping or queued.
REQ-016 SHALL have port level  out  $clog2(DEPTH+1)  meaning FIFO occupancy.
REQ-017 SHALL have port cur_freq  out  FREQ_W  meaning frequency being played, 0 outside TONE.

Function
REQ-018 SHALL push {note_freq,note_dur} when note_valid && note_ready; note_ready = !full && !flush && !rst (combinational).
REQ-019 SHALL implement states IDLE, TONE, GAP; IDLE with level>0 pops the head and enters TONE on the next edge.
REQ-020 SHALL discard a popped note with note_dur==0 (no TONE cycles) and proceed as at note end.
REQ-021 SHALL, on every note start, clear the tick counter, ms counter and phase accumulator, and drive sound=0.
REQ-022 SHALL raise an internal ms tick when the tick counter equals ticks_per_milli-1, then wrap it to 0.
REQ-023 SHALL hold TONE for exactly note_dur ms (note_dur*ticks_per_milli cycles).
REQ-024 SHALL, at TONE end, enter GAP for gap_ms ms if gap_ms!=0; otherwise go directly to the next note's TONE if level>0 (no idle cycle), else IDLE.
REQ-025 SHALL, at GAP end, enter TONE with the next note if level>0, else IDLE.
REQ-026 SHALL, in TONE with freq!=0, add freq to a 32-bit accumulator each cycle; when the pre-add value >= (ticks_per_milli*1000)>>1, toggle sound and subtract that half-period.
REQ-027 SHALL compute ticks_per_milli*1000 at 32 bits without truncation.
REQ-028 SHALL force sound=0 in IDLE, GAP, rest notes and while pause is high.
REQ-029 SHALL, while pause=1, hold all counters, accumulator and state; FIFO pushes remain accepted.
REQ-030 SHALL, on flush, go to IDLE, set level=0, cur_freq=0 and sound=0 at the next edge; flush beats a same-cycle push and pop.
REQ-031 SHALL allow a pop and push in the same cycle (level unchanged), including when full at pop time is not yet cleared (ready stays low that cycle).
REQ-032 SHALL drive busy = (state!=IDLE) || (level!=0).

Reset
REQ-033 SHALL, when rst=1, set state=IDLE, level=0, sound=0, cur_freq=0, busy=0, all counters and accumulator 0; note_ready=0 during rst, 1 the first cycle after.
REQ-034 SHALL let rst override flush, pause and push, including mid-note.

Verification
REQ-035 SHALL test: tpm=2, gap=0, push {500,3} -> TONE 6 cycles, sound toggles every 2 cycles (period 4), busy falls after, sound=0.
REQ-036 SHALL test: push DEPTH notes without pop-stall -> level=DEPTH, note_ready=0, extra push ignored; FIFO order preserved on playback.
REQ-037 SHALL test: tpm=2, gap=2, notes {500,2},{0,1},{250,2} -> 4 tone, 4 gap, 2 silent, 4 gap, 4 tone cycles; cur_freq 500,0,0,0,250.
REQ-038 SHALL test: flush mid-TONE with 3 queued -> next cycle IDLE, level=0, sound=0, busy=0.
REQ-039 SHALL test: pause asserted 10 cycles mid-note -> sound=0, note lengthens by exactly 10 cycles.
REQ-040 SHALL test: rst mid-TONE with level=4 -> all outputs at reset values next cycle; note_dur=0 note is skipped with no TONE cycles.
